// File: rtl/fifo_sync_ctl.sv
// Single-clock elastic buffer for any DEPTH >= 2, with occupancy count, programmable level flags and sticky errors.
// Latency: a push into an empty FIFO shows on data_out after one edge (show-ahead); flags decode registered count.
// Backpressure: push is refused while full unless a pop is accepted the same cycle; pop is refused while empty.
module fifo_sync_ctl #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int PTRWID   = $clog2(DEPTH),
    parameter int CNTWID   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNTWID-1:0] count,
    output logic [CNTWID-1:0] high_water,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    generate
        if (DEPTH < 2 || AF_LEVEL < 1 || AF_LEVEL > DEPTH ||
            AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_params
            $error("fifo_sync_ctl: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
        end
    endgenerate

    localparam logic [CNTWID-1:0] DEPTH_C  = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0] AF_C     = CNTWID'(AF_LEVEL);
    localparam logic [CNTWID-1:0] AE_C     = CNTWID'(AE_LEVEL);
    localparam logic [PTRWID-1:0] PTR_LAST = PTRWID'(DEPTH - 1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTRWID-1:0] wr_ptr;
    logic [PTRWID-1:0] rd_ptr;
    logic [CNTWID-1:0] count_q;
    logic [CNTWID-1:0] count_nxt;
    logic [CNTWID-1:0] hw_q;
    logic              ovf_q;
    logic              unf_q;

    logic pop_ok;
    logic push_ok;
    logic push_acc;
    logic pop_acc;
    logic ovf_set;
    logic unf_set;

    // Explicit wrap so non-power-of-two depths never touch entries >= DEPTH.
    function automatic logic [PTRWID-1:0] ptr_inc(input logic [PTRWID-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTRWID'(1);
    endfunction

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign high_water   = hw_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign data_out     = mem[rd_ptr];

    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Flush swallows this cycle's requests entirely, including their error side effects.
    assign push_acc = push_ok & ~flush;
    assign pop_acc  = pop_ok & ~flush;
    assign ovf_set  = push & full & ~pop_ok & ~flush;
    assign unf_set  = pop & empty & ~flush;

    always_comb begin
        count_nxt = count_q;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push_acc, pop_acc})
                2'b10:   count_nxt = count_q + CNTWID'(1);
                2'b01:   count_nxt = count_q - CNTWID'(1);
                default: count_nxt = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_acc) wr_ptr <= ptr_inc(wr_ptr);
                if (pop_acc)  rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // A set condition coinciding with clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            hw_q  <= '0;
        end else begin
            ovf_q <= ovf_set | (ovf_q & ~clr_err);
            unf_q <= unf_set | (unf_q & ~clr_err);
            if (clr_err) begin
                hw_q <= count_q;
            end else if (count_nxt > hw_q) begin
                hw_q <= count_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule
